// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared definitions for the DDS sweep controller: default widths, mode codes and FSM states.
package dds_sweep_ctrl_pkg;

  localparam int KW_DEFAULT      = 32;
  localparam int DWELL_W_DEFAULT = 16;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

  // The step decision is taken inside the expiring dwell cycle, so no separate step state exists.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DWELL = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

endpackage

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Loadable dwell down-counter; expire is high for the single cycle in which the count reaches zero.
module sweep_dwell_timer
  import dds_sweep_ctrl_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [DWELL_W-1:0] load_val,
  output logic               expire
);

  localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  logic [DWELL_W-1:0] count_r;
  logic               armed_r;

  // Count down after a load; disarm once zero has been reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      armed_r <= 1'b0;
    end else if (clear) begin
      count_r <= '0;
      armed_r <= 1'b0;
    end else if (load) begin
      count_r <= load_val;
      armed_r <= 1'b1;
    end else if (armed_r) begin
      if (count_r == '0) begin
        armed_r <= 1'b0;
      end else begin
        count_r <= count_r - ONE;
      end
    end
  end

  assign expire = armed_r && (count_r == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller driving the DDS word K, its load strobe Ken and the run enable.
module dds_sweep_ctrl
  import dds_sweep_ctrl_pkg::*;
#(
  parameter int KW      = KW_DEFAULT,
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [KW-1:0]      k_start,
  input  logic [KW-1:0]      k_stop,
  input  logic [KW-1:0]      k_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         mode,
  output logic [KW-1:0]      K,
  output logic               Ken,
  output logic               dds_en,
  output logic               busy,
  output logic               done
);

  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  // Next word with carry/borrow and overshoot clamped to the endpoint; a zero step jumps there.
  function automatic logic [KW-1:0] step_next(input logic [KW-1:0] cur, input logic [KW-1:0] step,
                                              input logic [KW-1:0] stop, input logic up);
    logic [KW:0] nxt;
    logic        clamp;
    if (up) begin
      nxt   = {1'b0, cur} + {1'b0, step};
      clamp = nxt[KW] || (nxt[KW-1:0] > stop);
    end else begin
      nxt   = {1'b0, cur} - {1'b0, step};
      clamp = nxt[KW] || (nxt[KW-1:0] < stop);
    end
    if (step == '0) begin
      clamp = 1'b1;
    end else begin
      clamp = clamp;
    end
    return clamp ? stop : nxt[KW-1:0];
  endfunction

  state_t             state_r, state_s;
  logic [KW-1:0]      start_sh_r, stop_sh_r, step_sh_r;
  logic [DWELL_W-1:0] dwell_m1_r;
  logic [1:0]         mode_sh_r;
  logic               up_r;
  logic [KW-1:0]      k_s;
  logic [DWELL_W-1:0] dwell_ld_s;
  logic               capture_s, swap_s, timer_load_s, expire_s;

  sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_s),
    .clear    (abort),
    .load_val (dwell_ld_s),
    .expire   (expire_s)
  );

  // Next-state, next word and shadow-register control.
  always_comb begin
    state_s      = state_r;
    k_s          = K;
    capture_s    = 1'b0;
    swap_s       = 1'b0;
    timer_load_s = 1'b0;
    dwell_ld_s   = dwell_m1_r;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s      = ST_LOAD;
            k_s          = k_start;
            capture_s    = 1'b1;
            timer_load_s = 1'b1;
            dwell_ld_s   = (dwell == '0) ? '0 : dwell - DWELL_ONE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOAD, ST_DWELL: begin
          state_s = ST_DWELL;
          if (expire_s && (K != stop_sh_r)) begin
            state_s      = ST_LOAD;
            k_s          = step_next(K, step_sh_r, stop_sh_r, up_r);
            timer_load_s = 1'b1;
          end else if (expire_s) begin
            case (mode_sh_r)
              MODE_SAW: begin
                state_s      = ST_LOAD;
                k_s          = start_sh_r;
                timer_load_s = 1'b1;
              end
              MODE_TRI: begin
                // Turn around: the old start becomes the new stop; equal endpoints just hold.
                if (start_sh_r != stop_sh_r) begin
                  state_s      = ST_LOAD;
                  swap_s       = 1'b1;
                  k_s          = step_next(K, step_sh_r, start_sh_r, !up_r);
                  timer_load_s = 1'b1;
                end else begin
                  state_s = ST_DWELL;
                end
              end
              default: state_s = ST_DONE;
            endcase
          end else begin
            state_s = ST_DWELL;
          end
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State register and registered DDS-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      K       <= '0;
      Ken     <= 1'b0;
      dds_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      Ken     <= (state_s == ST_LOAD);
      busy    <= (state_s == ST_LOAD) || (state_s == ST_DWELL);
      done    <= (state_s == ST_DONE);
      if (state_s == ST_LOAD) begin
        K <= k_s;
      end
      if (abort) begin
        dds_en <= 1'b0;
      end else if (state_s == ST_LOAD) begin
        dds_en <= 1'b1;
      end
    end
  end

  // Shadow configuration, captured on an accepted start and swapped at triangle turn points.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sh_r <= '0;
      stop_sh_r  <= '0;
      step_sh_r  <= '0;
      dwell_m1_r <= '0;
      mode_sh_r  <= MODE_SINGLE;
      up_r       <= 1'b0;
    end else if (capture_s) begin
      start_sh_r <= k_start;
      stop_sh_r  <= k_stop;
      step_sh_r  <= k_step;
      dwell_m1_r <= dwell_ld_s;
      mode_sh_r  <= mode;
      up_r       <= (k_start <= k_stop);
    end else if (swap_s) begin
      start_sh_r <= stop_sh_r;
      stop_sh_r  <= start_sh_r;
      up_r       <= !up_r;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench: expected Ken/done events are queued at stimulus time and matched as they appear.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [31:0] k_start = 32'd0, k_stop = 32'd0, k_step = 32'd0;
  logic [15:0] dwell = 16'd0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] K;
  logic        Ken, dds_en, busy, done;

  int cyc = 0, tests_run = 0, fails = 0;

  typedef struct { int cyc; logic [31:0] k; } ken_exp_t;
  ken_exp_t ken_q[$];
  int       done_q[$];
  ken_exp_t ke;
  int       de;

  dds_sweep_ctrl #(.KW(32), .DWELL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .k_start(k_start), .k_stop(k_stop), .k_step(k_step), .dwell(dwell), .mode(mode),
    .K(K), .Ken(Ken), .dds_en(dds_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every Ken and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (Ken === 1'b1) begin
      tests_run++;
      if (ken_q.size() == 0) begin
        fails++;
        $display("FAIL ken_unexpected: cyc=%0d K=%h, required no Ken", cyc, K);
      end else begin
        ke = ken_q.pop_front();
        if (ke.cyc != cyc || ke.k !== K) begin
          fails++;
          $display("FAIL ken_match: got cyc=%0d K=%h, required cyc=%0d K=%h", cyc, K, ke.cyc, ke.k);
        end
      end
    end
    if (done === 1'b1) begin
      tests_run++;
      if (done_q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected: cyc=%0d, required no done", cyc);
      end else begin
        de = done_q.pop_front();
        if (de != cyc) begin
          fails++;
          $display("FAIL done_match: got cyc=%0d, required cyc=%0d", cyc, de);
        end
      end
    end
  end

  task automatic start_sweep(input logic [1:0] m, input logic [31:0] ks, input logic [31:0] kt,
                             input logic [31:0] st, input logic [15:0] dw, output int t);
    @(negedge clk);
    t = cyc;
    mode = m; k_start = ks; k_stop = kt; k_step = st; dwell = dw;
    start = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (K !== 32'd0 || Ken !== 1'b0 || dds_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: K=%h Ken=%b en=%b busy=%b done=%b, required all 0", K, Ken, dds_en, busy, done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_sweep();
    int t;
    start_sweep(2'd0, 32'd100, 32'd400, 32'd100, 16'd3, t);
    ken_q.push_back('{t + 1, 32'd100});
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (K !== 32'd0 || dds_en !== 1'b0 || busy !== 1'b0 || Ken !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: K=%h en=%b busy=%b Ken=%b, required 0 0 0 0", K, dds_en, busy, Ken);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (ken_q.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_queue: %0d Ken pending, required 0", ken_q.size());
    end
  endtask

  task automatic test_up_sweep();
    int t;
    start_sweep(2'd0, 32'd100, 32'd400, 32'd100, 16'd3, t);
    for (int i = 0; i < 4; i++) ken_q.push_back('{t + 1 + 3 * i, 32'd100 + 32'd100 * i});
    done_q.push_back(t + 13);
    @(negedge clk); start = 1'b0;
    repeat (13) @(negedge clk);
    tests_run++;
    if (ken_q.size() != 0 || done_q.size() != 0) begin
      fails++;
      $display("FAIL up_pending: ken=%0d done=%0d left, required 0 0", ken_q.size(), done_q.size());
    end
    tests_run++;
    if (dds_en !== 1'b1 || K !== 32'd400 || busy !== 1'b0) begin
      fails++;
      $display("FAIL up_tone_hold: en=%b K=%0d busy=%b, required 1 400 0", dds_en, K, busy);
    end
  endtask

  task automatic test_clamp();
    int t;
    start_sweep(2'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd1, t);
    ken_q.push_back('{t + 1, 32'hFFFF_FF00});
    ken_q.push_back('{t + 2, 32'hFFFF_FF80});
    ken_q.push_back('{t + 3, 32'hFFFF_FFFF});
    done_q.push_back(t + 4);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start_sweep(2'd0, 32'd50, 32'd0, 32'd20, 16'd1, t);
    ken_q.push_back('{t + 1, 32'd50});
    ken_q.push_back('{t + 2, 32'd30});
    ken_q.push_back('{t + 3, 32'd10});
    ken_q.push_back('{t + 4, 32'd0});
    done_q.push_back(t + 5);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (ken_q.size() != 0 || done_q.size() != 0) begin
      fails++;
      $display("FAIL clamp_pending: ken=%0d done=%0d left, required 0 0", ken_q.size(), done_q.size());
    end
  endtask

  task automatic test_triangle();
    int t;
    logic [31:0] seq [8];
    seq = '{32'd10, 32'd20, 32'd30, 32'd20, 32'd10, 32'd20, 32'd30, 32'd20};
    start_sweep(2'd2, 32'd10, 32'd30, 32'd10, 16'd2, t);
    for (int i = 0; i < 8; i++) ken_q.push_back('{t + 1 + 2 * i, seq[i]});
    @(negedge clk); start = 1'b0;
    while (cyc < t + 16) begin
      tests_run++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL tri_busy: cyc=%0d busy=%b, required 1", cyc, busy);
      end
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || dds_en !== 1'b0 || ken_q.size() != 0) begin
      fails++;
      $display("FAIL tri_stop: busy=%b en=%b pending=%0d, required 0 0 0", busy, dds_en, ken_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort_and_busy_start();
    int t;
    start_sweep(2'd0, 32'd100, 32'd400, 32'd100, 16'd3, t);
    ken_q.push_back('{t + 1, 32'd100});
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || dds_en !== 1'b0 || done !== 1'b0 || K !== 32'd100) begin
      fails++;
      $display("FAIL abort_dwell: busy=%b en=%b done=%b K=%0d, required 0 0 0 100", busy, dds_en, done, K);
    end
    repeat (5) @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || dds_en !== 1'b0) begin
      fails++;
      $display("FAIL start_abort_same: busy=%b en=%b, required 0 0", busy, dds_en);
    end
    repeat (4) @(negedge clk);
    start_sweep(2'd1, 32'd1, 32'd3, 32'd1, 16'd2, t);
    ken_q.push_back('{t + 1, 32'd1});
    ken_q.push_back('{t + 3, 32'd2});
    ken_q.push_back('{t + 5, 32'd3});
    ken_q.push_back('{t + 7, 32'd1});
    ken_q.push_back('{t + 9, 32'd2});
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    k_start = 32'd50; k_stop = 32'd60; mode = 2'd0; dwell = 16'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (ken_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_start: pending=%0d busy=%b, required 0 0", ken_q.size(), busy);
    end
  endtask

  task automatic test_degenerate();
    int t;
    start_sweep(2'd0, 32'd0, 32'd3, 32'd1, 16'd0, t);
    for (int i = 0; i < 4; i++) ken_q.push_back('{t + 1 + i, 32'(i)});
    done_q.push_back(t + 5);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    start_sweep(2'd0, 32'd5, 32'd9, 32'd0, 16'd2, t);
    ken_q.push_back('{t + 1, 32'd5});
    ken_q.push_back('{t + 3, 32'd9});
    done_q.push_back(t + 5);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    start_sweep(2'd3, 32'd7, 32'd7, 32'd4, 16'd3, t);
    ken_q.push_back('{t + 1, 32'd7});
    done_q.push_back(t + 4);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (ken_q.size() != 0 || done_q.size() != 0 || K !== 32'd7 || dds_en !== 1'b1) begin
      fails++;
      $display("FAIL degenerate: ken=%0d done=%0d K=%0d en=%b, required 0 0 7 1",
               ken_q.size(), done_q.size(), K, dds_en);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_sweep();
    test_up_sweep();
    test_clamp();
    test_triangle();
    test_abort_and_busy_start();
    test_degenerate();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
